// File: rtl/apb_cmd_master.sv
// apb_cmd_master: FIFO-buffered APB3 master returning one response per command
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [DATA_WIDTH-1:0]        cmd_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         PSELx,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_WIDTH-1:0]        PADDR,
  output logic [DATA_WIDTH-1:0]        PWDATA,
  input  logic                         PREADY,
  input  logic [DATA_WIDTH-1:0]        PRDATA,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level,
  output logic                         busy
);
  localparam int LW = $clog2(CMD_DEPTH);
  localparam int LVW = LW + 1;
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] TMAX = WW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] mem_addr [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [CMD_DEPTH];
  logic                  mem_write [CMD_DEPTH];
  logic [LW-1:0] wr_ptr, rd_ptr;
  logic [WW-1:0] wait_cnt;
  logic push, pop, empty, slot_free, timeout, done;
  assign empty     = cmd_level == '0;
  assign cmd_ready = cmd_level != LVW'(CMD_DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign slot_free = !rsp_valid || rsp_ready;
  assign timeout   = TIMEOUT != 0 && wait_cnt == TMAX && !PREADY;
  assign done      = state == ACCESS && (PREADY || timeout);
  // a back-to-back issue needs the consumer ready, since this completion is about to occupy the slot
  assign pop       = !empty && (state == IDLE ? slot_free : done && rsp_ready);
  assign busy      = state != IDLE || !empty;
  // command storage; entries are only read after they are counted in cmd_level, so no bypass
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_addr[wr_ptr]  <= cmd_addr;
      mem_data[wr_ptr]  <= cmd_wdata;
      mem_write[wr_ptr] <= cmd_write;
    end
  end
  // FIFO pointers and occupancy
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cmd_level <= cmd_level + LVW'(push) - LVW'(pop);
    end
  end
  // APB transfer sequencing and response slot
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (pop) begin
        PADDR  <= mem_addr[rd_ptr];
        PWRITE <= mem_write[rd_ptr];
        PWDATA <= mem_write[rd_ptr] ? mem_data[rd_ptr] : '0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            state <= SETUP;
            PSELx <= 1'b1;
          end
        end
        SETUP: begin
          state    <= ACCESS;
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= timeout;
            rsp_rdata <= PREADY && !PWRITE ? PRDATA : '0;
            PENABLE   <= 1'b0;
            state     <= pop ? SETUP : IDLE;
            PSELx     <= pop;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          PSELx   <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed scenario tests for apb_cmd_master
module tb_apb_cmd_master;
  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSELx, PENABLE, PWRITE, PREADY;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic [2:0] cmd_level;
  logic       busy;
  logic [7:0] acc_cnt;
  logic [7:0] ws = 8'd0;
  logic       stuck = 1'b0;
  int errors = 0;
  int checks = 0;
  apb_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .CMD_DEPTH(4), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .cmd_level(cmd_level), .busy(busy)
  );
  always #5 PCLK = ~PCLK;
  // slave: ready after ws wait states unless stuck; read data derived from the address
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) acc_cnt <= '0;
    else acc_cnt <= (PSELx && PENABLE && !PREADY) ? acc_cnt + 8'd1 : 8'd0;
  end
  assign PREADY = !stuck && acc_cnt == ws;
  assign PRDATA = PADDR ^ 8'hC7;
  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask
  task automatic test_reset;
    PRESETn = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({PSELx, PENABLE, rsp_valid, busy, cmd_ready, cmd_level} !== 8'b0000_1000) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%b en=%b rv=%b busy=%b rdy=%b lvl=%0d required 0 0 0 0 1 0",
               PSELx, PENABLE, rsp_valid, busy, cmd_ready, cmd_level);
    end
    checks++;
    if ({PADDR, PWDATA, rsp_rdata} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h required 00", PADDR, PWDATA, rsp_rdata);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
  endtask
  task automatic test_single_write;
    ws = 8'd0;
    rsp_ready = 1'b0;
    push(1'b1, 8'h02, 8'h5A);
    checks++;
    if (cmd_level !== 3'd1 || PSELx !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: got lvl=%0d sel=%b required 1 0", cmd_level, PSELx);
    end
    @(negedge PCLK);
    checks++;
    if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 8'h02, 8'h5A}) begin
      errors++;
      $display("FAIL wr_setup: got sel=%b en=%b w=%b a=%h d=%h required 1 0 1 02 5a",
               PSELx, PENABLE, PWRITE, PADDR, PWDATA);
    end
    @(negedge PCLK);
    checks++;
    if ({PSELx, PENABLE, PADDR, PWDATA} !== {2'b11, 8'h02, 8'h5A}) begin
      errors++;
      $display("FAIL wr_access: got sel=%b en=%b a=%h d=%h required 1 1 02 5a", PSELx, PENABLE, PADDR, PWDATA);
    end
    @(negedge PCLK);
    checks++;
    if ({PSELx, PENABLE, rsp_valid, rsp_err, rsp_rdata} !== {4'b0010, 8'h00}) begin
      errors++;
      $display("FAIL wr_rsp: got sel=%b en=%b rv=%b err=%b rd=%h required 0 0 1 0 00",
               PSELx, PENABLE, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge PCLK);
    checks++;
    if (rsp_valid !== 1'b1 || PADDR !== 8'h02) begin
      errors++;
      $display("FAIL rsp_hold: got rv=%b paddr=%h required 1 02", rsp_valid, PADDR);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rsp_consume: got rv=%b busy=%b required 0 0", rsp_valid, busy);
    end
  endtask
  task automatic test_read_wait;
    int pen = 0;
    logic [7:0] wd = 8'hFF;
    logic seen = 1'b0;
    ws = 8'd3;
    push(1'b0, 8'h04, 8'hEE);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK);
      if (PENABLE) begin
        pen++;
        wd = PWDATA;
      end
      seen = rsp_valid;
    end
    checks++;
    if (pen !== 4 || !seen) begin
      errors++;
      $display("FAIL read_wait_cycles: got penable=%0d seen=%b required 4 1", pen, seen);
    end
    checks++;
    if (rsp_rdata !== 8'hC3 || rsp_err !== 1'b0 || wd !== 8'h00) begin
      errors++;
      $display("FAIL read_data: got rd=%h err=%b pwdata=%h required c3 0 00", rsp_rdata, rsp_err, wd);
    end
    ws = 8'd0;
  endtask
  task automatic test_back_to_back;
    int sel = 0, rises = 0, nrsp = 0;
    logic prev = 1'b0;
    logic [31:0] seq = '0;
    logic [8:0] rsp_or = '0;
    for (int k = 0; k < 4; k++) push(1'b1, 8'(k), 8'(8'h10 + k));
    checks++;
    if (cmd_level !== 3'd4 || cmd_ready !== 1'b0 || PSELx !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: got lvl=%0d rdy=%b sel=%b required 4 0 0", cmd_level, cmd_ready, PSELx);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (PSELx) sel++;
      if (PSELx && !prev) rises++;
      if (PSELx && !PENABLE) seq = {seq[23:0], PADDR};
      if (rsp_valid) begin
        nrsp++;
        rsp_or = rsp_or | {rsp_err, rsp_rdata};
      end
      prev = PSELx;
    end
    rsp_ready = 1'b0;
    checks++;
    if (sel !== 8 || rises !== 1) begin
      errors++;
      $display("FAIL b2b_contiguous: got sel_cycles=%0d bursts=%0d required 8 1", sel, rises);
    end
    checks++;
    if (seq !== 32'h00010203) begin
      errors++;
      $display("FAIL b2b_order: got %h required 00010203", seq);
    end
    checks++;
    if (nrsp !== 4 || rsp_or !== 9'h0) begin
      errors++;
      $display("FAIL b2b_rsp: got count=%0d or=%h required 4 000", nrsp, rsp_or);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got rdy=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask
  task automatic test_timeout;
    int pen = 0;
    logic seen = 1'b0, got2 = 1'b0;
    stuck = 1'b1;
    rsp_ready = 1'b1;
    push(1'b0, 8'h08, 8'h00);
    push(1'b1, 8'h09, 8'h77);
    for (int i = 0; i < 60 && !got2; i++) begin
      @(negedge PCLK);
      if (!seen) begin
        if (PENABLE) pen++;
        if (rsp_valid) begin
          seen = 1'b1;
          stuck = 1'b0;
          checks++;
          if (rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL timeout_rsp: got err=%b rd=%h required 1 00", rsp_err, rsp_rdata);
          end
          checks++;
          if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 8'h09, 8'h77}) begin
            errors++;
            $display("FAIL timeout_next: got sel=%b en=%b w=%b a=%h d=%h required 1 0 1 09 77",
                     PSELx, PENABLE, PWRITE, PADDR, PWDATA);
          end
        end
      end else if (rsp_valid) begin
        got2 = 1'b1;
        checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin
          errors++;
          $display("FAIL after_timeout_rsp: got err=%b rd=%h required 0 00", rsp_err, rsp_rdata);
        end
      end
    end
    checks++;
    if (pen !== 16 || !got2) begin
      errors++;
      $display("FAIL timeout_cycles: got penable=%0d second=%b required 16 1", pen, got2);
    end
    stuck = 1'b0;
    @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask
  task automatic test_rsp_backpressure;
    int setups = 0;
    logic seen = 1'b0;
    rsp_ready = 1'b0;
    push(1'b0, 8'h10, 8'h00);
    push(1'b0, 8'h11, 8'h00);
    for (int i = 0; i < 12; i++) begin
      @(negedge PCLK);
      if (PSELx && !PENABLE) setups++;
    end
    checks++;
    if (setups !== 0 || rsp_valid !== 1'b1 || rsp_rdata !== 8'hD7 || cmd_level !== 3'd1) begin
      errors++;
      $display("FAIL bp_withheld: got setups=%0d rv=%b rd=%h lvl=%0d required 0 1 d7 1",
               setups, rsp_valid, rsp_rdata, cmd_level);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({PSELx, PENABLE, rsp_valid, PADDR} !== {3'b100, 8'h11}) begin
      errors++;
      $display("FAIL bp_release: got sel=%b en=%b rv=%b a=%h required 1 0 0 11", PSELx, PENABLE, rsp_valid, PADDR);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge PCLK);
      seen = rsp_valid;
    end
    checks++;
    if (!seen || rsp_rdata !== 8'hD6 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_second: got seen=%b rd=%h err=%b required 1 d6 0", seen, rsp_rdata, rsp_err);
    end
    @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset_mid;
    logic found = 1'b0;
    ws = 8'd2;
    rsp_ready = 1'b1;
    push(1'b0, 8'h20, 8'h00);
    push(1'b0, 8'h21, 8'h00);
    push(1'b0, 8'h22, 8'h00);
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge PCLK);
      if (rsp_valid) rsp_ready = 1'b0;
      found = PSELx && PENABLE && rsp_valid;
    end
    checks++;
    if (!found || cmd_level !== 3'd1 || PWRITE !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: got found=%b lvl=%0d w=%b required 1 1 0", found, cmd_level, PWRITE);
    end
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if ({PSELx, PENABLE, rsp_valid, cmd_ready, cmd_level} !== 7'b0001000) begin
      errors++;
      $display("FAIL async_reset: got sel=%b en=%b rv=%b rdy=%b lvl=%0d required 0 0 0 1 0",
               PSELx, PENABLE, rsp_valid, cmd_ready, cmd_level);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    ws = 8'd0;
    @(negedge PCLK);
    checks++;
    if (busy !== 1'b0 || PSELx !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b sel=%b rv=%b required 0 0 0", busy, PSELx, rsp_valid);
    end
  endtask
  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_rsp_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
endmodule
